// File: rtl/abacus_seq_alu.sv
// abacus_seq_alu: multi-cycle add/sub/mul/div engine with serial binary-to-BCD conversion.
// Result, flags and BCD digits are registered on entry to DONE and held until the next completion.
module abacus_seq_alu #(
    parameter int W    = 8,
    parameter int NDIG = 5
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic              busy,
    output logic              done,
    output logic [2*W-1:0]    result,
    output logic              neg,
    output logic              dbz,
    output logic [4*NDIG-1:0] bcd,
    output logic [4*NDIG-1:0] bcd_rem
);

    localparam int CW = $clog2(2*W + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        BCD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                accept_s;
    logic                exec_last_s;
    logic                bcd_last_s;

    logic [1:0]          op_r;
    logic [W-1:0]        a_r;
    logic [W-1:0]        b_r;
    logic [CW-1:0]       cnt_r;
    logic [2*W-1:0]      acc_r;
    logic [2*W-1:0]      bin_r;
    logic [2*W-1:0]      binr_r;
    logic [4*NDIG-1:0]   dig_r;
    logic [4*NDIG-1:0]   digr_r;
    logic                neg_r;
    logic                dbz_r;

    logic [W:0]          mul_sum_s;
    logic [W:0]          div_shift_s;
    logic                div_ge_s;
    logic [W-1:0]        div_sub_s;
    logic [4*NDIG-1:0]   dig_s;
    logic [4*NDIG-1:0]   digr_s;

    // One double-dabble step: add 3 to every digit >= 5, then shift the next binary bit in.
    function automatic logic [4*NDIG-1:0] dabble(input logic [4*NDIG-1:0] dig,
                                                  input logic              bit_in);
        logic [4*NDIG-1:0] adj;
        adj = dig;
        for (int i = 0; i < NDIG; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        return {adj[4*NDIG-2:0], bit_in};
    endfunction

    // Next-state decode; DONE accepts a new request exactly like IDLE.
    always_comb begin
        state_s     = state_r;
        accept_s    = 1'b0;
        exec_last_s = 1'b0;
        bcd_last_s  = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = EXEC;
                end else begin
                    state_s  = IDLE;
                end
            end
            EXEC: begin
                // mul/div spend W iteration cycles plus one cycle loading the BCD shifters
                exec_last_s = (op_r[1] == 1'b0) || (cnt_r == CW'(W));
                if (exec_last_s) begin
                    state_s = BCD;
                end else begin
                    state_s = EXEC;
                end
            end
            BCD: begin
                bcd_last_s = (cnt_r == CW'(2*W - 1));
                if (bcd_last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = BCD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Per-cycle arithmetic step terms and BCD step results.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*W-1:W]} + {1'b0, (acc_r[0] ? a_r : {W{1'b0}})};
        div_shift_s = {acc_r[2*W-1:W], acc_r[W-1]};
        div_ge_s    = (div_shift_s >= {1'b0, b_r});
        div_sub_s   = div_shift_s[W-1:0] - b_r;
        dig_s       = dabble(dig_r, bin_r[2*W-1]);
        digr_s      = dabble(digr_r, binr_r[2*W-1]);
    end

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, iterative mul/div and serial BCD conversion.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            op_r   <= 2'b00;
            a_r    <= {W{1'b0}};
            b_r    <= {W{1'b0}};
            cnt_r  <= {CW{1'b0}};
            acc_r  <= {(2*W){1'b0}};
            bin_r  <= {(2*W){1'b0}};
            binr_r <= {(2*W){1'b0}};
            dig_r  <= {(4*NDIG){1'b0}};
            digr_r <= {(4*NDIG){1'b0}};
            neg_r  <= 1'b0;
            dbz_r  <= 1'b0;
        end else if (accept_s) begin
            op_r  <= op;
            a_r   <= a;
            b_r   <= b;
            cnt_r <= {CW{1'b0}};
            neg_r <= 1'b0;
            dbz_r <= 1'b0;
            case (op)
                OP_ADD: acc_r <= {{(W-1){1'b0}}, ({1'b0, a} + {1'b0, b})};
                OP_SUB: begin
                    neg_r <= (a < b);
                    acc_r <= {{W{1'b0}}, ((a < b) ? (b - a) : (a - b))};
                end
                // multiplier sits in the low half and is shifted out as the product grows
                OP_MUL: acc_r <= {{W{1'b0}}, b};
                // dividend in the low half; remainder builds in the high half
                OP_DIV: begin
                    dbz_r <= (b == {W{1'b0}});
                    acc_r <= {{W{1'b0}}, a};
                end
                default: acc_r <= {(2*W){1'b0}};
            endcase
        end else if (state_r == EXEC) begin
            if (exec_last_s) begin
                cnt_r  <= {CW{1'b0}};
                dig_r  <= {(4*NDIG){1'b0}};
                digr_r <= {(4*NDIG){1'b0}};
                if (op_r == OP_DIV) begin
                    bin_r  <= {{W{1'b0}}, acc_r[W-1:0]};
                    binr_r <= {{W{1'b0}}, acc_r[2*W-1:W]};
                end else begin
                    bin_r  <= acc_r;
                    binr_r <= {(2*W){1'b0}};
                end
            end else begin
                cnt_r <= cnt_r + CW'(1);
                if (op_r == OP_MUL) begin
                    acc_r <= {mul_sum_s, acc_r[W-1:1]};
                end else if (div_ge_s) begin
                    // a zero divisor always subtracts, leaving all-ones quotient and remainder a
                    acc_r <= {div_sub_s, acc_r[W-2:0], 1'b1};
                end else begin
                    acc_r <= {div_shift_s[W-1:0], acc_r[W-2:0], 1'b0};
                end
            end
        end else if (state_r == BCD) begin
            cnt_r  <= cnt_r + CW'(1);
            dig_r  <= dig_s;
            digr_r <= digr_s;
            bin_r  <= {bin_r[2*W-2:0], 1'b0};
            binr_r <= {binr_r[2*W-2:0], 1'b0};
        end
    end

    // Registered handshake and held result outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= {(2*W){1'b0}};
            neg     <= 1'b0;
            dbz     <= 1'b0;
            bcd     <= {(4*NDIG){1'b0}};
            bcd_rem <= {(4*NDIG){1'b0}};
        end else begin
            busy <= (state_s == EXEC) || (state_s == BCD);
            done <= (state_s == DONE);
            if (bcd_last_s) begin
                result  <= acc_r;
                neg     <= neg_r;
                dbz     <= dbz_r;
                bcd     <= dig_s;
                bcd_rem <= digr_s;
            end
        end
    end

endmodule
